// File: rtl/serial_adder_pkg.sv
// Shared types and sizing helpers for the chunked serial adder.
package serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  function automatic int calc_n(input int width, input int chunk);
    return width / chunk;
  endfunction

  function automatic int calc_cnt_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/serial_adder_chunk_adder.sv
// CHUNK-bit ripple adder built from full adders, themselves built from half adders.
// c_msb_in exposes the carry into the top bit so the caller can derive signed overflow.
module half_adder (
  input  logic a,
  input  logic b,
  output logic s,
  output logic c
);
  assign s = a ^ b;
  assign c = a & b;
endmodule

module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);
  logic s0_s;
  logic c0_s;
  logic c1_s;

  half_adder u_ha0 (.a(a),    .b(b),   .s(s0_s), .c(c0_s));
  half_adder u_ha1 (.a(s0_s), .b(cin), .s(s),    .c(c1_s));

  assign cout = c0_s | c1_s;
endmodule

module chunk_adder #(
  parameter int CHUNK = 1
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             cin,
  output logic [CHUNK-1:0] s,
  output logic             cout,
  output logic             c_msb_in
);
  logic [CHUNK:0] c_s;

  assign c_s[0] = cin;

  for (genvar i = 0; i < CHUNK; i++) begin : g_bit
    full_adder u_fa (
      .a   (a[i]),
      .b   (b[i]),
      .cin (c_s[i]),
      .s   (s[i]),
      .cout(c_s[i+1])
    );
  end

  assign cout     = c_s[CHUNK];
  assign c_msb_in = c_s[CHUNK-1];
endmodule

// File: rtl/serial_adder.sv
// Multi-cycle WIDTH-bit adder processing CHUNK bits per clock with a start/done handshake.
// Define SERIAL_ADDER_SUB_EN to add the in_sub port for two's-complement subtraction.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CHUNK = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             in_sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             carry,
  output logic             overflow
);

  localparam int N  = calc_n(WIDTH, CHUNK);
  localparam int CW = calc_cnt_w(N);
  localparam logic [CW-1:0] LAST_CNT = CW'(N - 1);

  state_e           state_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] r_q;
  logic             c_q;
  logic [CW-1:0]    cnt_q;
  logic             busy_q;
  logic             done_q;
  logic [WIDTH-1:0] sum_q;
  logic             carry_q;
  logic             ovf_q;

  logic [CHUNK-1:0] s_s;
  logic             cout_s;
  logic             c_msb_s;
  logic [WIDTH-1:0] a_d;
  logic [WIDTH-1:0] b_d;
  logic [WIDTH-1:0] r_d;
  logic [CW-1:0]    cnt_d;
  logic [WIDTH-1:0] b_load_s;
  logic             c_load_s;

  chunk_adder #(.CHUNK(CHUNK)) u_chunk (
    .a       (a_q[CHUNK-1:0]),
    .b       (b_q[CHUNK-1:0]),
    .cin     (c_q),
    .s       (s_s),
    .cout    (cout_s),
    .c_msb_in(c_msb_s)
  );

  // Operand shift, result insertion from the MSB end, and start-time operand selection.
  always_comb begin
    a_d   = a_q >> CHUNK;
    b_d   = b_q >> CHUNK;
    r_d   = WIDTH'({s_s, r_q} >> CHUNK);
    cnt_d = cnt_q + CW'(1);
`ifdef SERIAL_ADDER_SUB_EN
    if (in_sub) begin
      b_load_s = ~in_b;
      c_load_s = 1'b1;
    end else begin
      b_load_s = in_b;
      c_load_s = 1'b0;
    end
`else
    b_load_s = in_b;
    c_load_s = 1'b0;
`endif
  end

  // Control FSM and all datapath/output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      r_q     <= '0;
      c_q     <= 1'b0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          done_q <= 1'b0;
          if (start) begin
            state_q <= RUN;
            a_q     <= in_a;
            b_q     <= b_load_s;
            r_q     <= '0;
            c_q     <= c_load_s;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
          end else begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        end
        RUN: begin
          a_q   <= a_d;
          b_q   <= b_d;
          r_q   <= r_d;
          c_q   <= cout_s;
          cnt_q <= cnt_d;
          if (cnt_q == LAST_CNT) begin
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            sum_q   <= r_d;
            carry_q <= cout_s;
            ovf_q   <= cout_s ^ c_msb_s;
          end else begin
            state_q <= RUN;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign sum      = sum_q;
  assign carry    = carry_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_serial_adder.sv
// Scoreboard bench for serial_adder: CHUNK=1 and CHUNK=4 instances, directed vectors.
module tb_serial_adder;

  typedef struct {
    logic [15:0] sum;
    logic        carry;
    logic        ovf;
    logic        sub;
    int          done_edge;
  } exp_t;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic [1:0]       start_v = 2'b00;
  logic [1:0][15:0] a_v = '0;
  logic [1:0][15:0] b_v = '0;
  logic [1:0]       sub_v = 2'b00;
  logic [1:0]       busy_v;
  logic [1:0]       done_v;
  logic [1:0][15:0] sum_v;
  logic [1:0]       carry_v;
  logic [1:0]       ovf_v;

  int   checks = 0;
  int   fails = 0;
  int   edge_cnt = 0;
  exp_t sb_q[2][$];
  exp_t held[2];
  exp_t mon_e;

  always #5 clk = ~clk;

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  serial_adder #(.WIDTH(16), .CHUNK(1)) u_c1 (
    .clk(clk), .reset(reset), .start(start_v[0]), .in_a(a_v[0]), .in_b(b_v[0]),
`ifdef SERIAL_ADDER_SUB_EN
    .in_sub(sub_v[0]),
`endif
    .busy(busy_v[0]), .done(done_v[0]), .sum(sum_v[0]), .carry(carry_v[0]), .overflow(ovf_v[0])
  );

  serial_adder #(.WIDTH(16), .CHUNK(4)) u_c4 (
    .clk(clk), .reset(reset), .start(start_v[1]), .in_a(a_v[1]), .in_b(b_v[1]),
`ifdef SERIAL_ADDER_SUB_EN
    .in_sub(sub_v[1]),
`endif
    .busy(busy_v[1]), .done(done_v[1]), .sum(sum_v[1]), .carry(carry_v[1]), .overflow(ovf_v[1])
  );

  task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s dut%0d: got %0h expected %0h", nm, k, act, exp);
    end
  endtask

  // Scoreboard monitor: pops on done, checks held outputs while busy.
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (!reset && done_v[k]) begin
        if (sb_q[k].size() == 0) begin
          checks++;
          fails++;
          $display("FAIL unexpected_done dut%0d: got done=1 expected no result pending", k);
        end else begin
          mon_e = sb_q[k].pop_front();
          chk($sformatf("sum(sub=%0b)", mon_e.sub), k, 32'(sum_v[k]), 32'(mon_e.sum));
          chk("carry", k, 32'(carry_v[k]), 32'(mon_e.carry));
          chk("overflow", k, 32'(ovf_v[k]), 32'(mon_e.ovf));
          chk("latency", k, 32'(edge_cnt), 32'(mon_e.done_edge));
          chk("busy_in_done", k, 32'(busy_v[k]), 32'd0);
          held[k] = mon_e;
        end
      end else if (!reset && busy_v[k]) begin
        chk("held_sum", k, 32'(sum_v[k]), 32'(held[k].sum));
        chk("held_carry", k, 32'(carry_v[k]), 32'(held[k].carry));
        chk("held_ovf", k, 32'(ovf_v[k]), 32'(held[k].ovf));
      end
    end
  end

  task automatic start_op(input int k, input logic [15:0] a, input logic [15:0] b,
                          input logic sub, input logic push,
                          input logic [15:0] es, input logic ec, input logic ev);
    exp_t e;
    a_v[k]     = a;
    b_v[k]     = b;
    sub_v[k]   = sub;
    start_v[k] = 1'b1;
    e.sum       = es;
    e.carry     = ec;
    e.ovf       = ev;
    e.sub       = sub_v[k];
    e.done_edge = edge_cnt + 1 + ((k == 0) ? 16 : 4);
    if (push) sb_q[k].push_back(e);
    @(posedge clk);
    #1;
    start_v[k] = 1'b0;
  endtask

  task automatic wait_done(input int k);
    int n = 0;
    @(negedge clk);
    while (!done_v[k] && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!done_v[k]) begin
      checks++;
      fails++;
      $display("FAIL timeout dut%0d: got no done within 40 cycles expected done", k);
    end
  endtask

  task automatic chk_idle(input int k);
    chk("rst_busy", k, 32'(busy_v[k]), 32'd0);
    chk("rst_done", k, 32'(done_v[k]), 32'd0);
    chk("rst_sum", k, 32'(sum_v[k]), 32'h0);
    chk("rst_carry", k, 32'(carry_v[k]), 32'd0);
    chk("rst_ovf", k, 32'(ovf_v[k]), 32'd0);
  endtask

  task automatic clear_held();
    for (int k = 0; k < 2; k++) begin
      held[k].sum   = 16'h0;
      held[k].carry = 1'b0;
      held[k].ovf   = 1'b0;
    end
  endtask

  initial begin
    clear_held();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    chk_idle(0);
    chk_idle(1);

    // CHUNK=1 additions, 16 busy cycles each
    start_op(0, 16'h1234, 16'h4321, 1'b0, 1'b1, 16'h5555, 1'b0, 1'b0);
    wait_done(0);
    @(negedge clk);
    chk("done_pulse", 0, 32'(done_v[0]), 32'd0);
    start_op(0, 16'h8000, 16'h8000, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b1);
    wait_done(0);

    // CHUNK=4 with back-to-back start in the DONE cycle
    @(negedge clk);
    start_op(1, 16'hFFFF, 16'h0001, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0);
    wait_done(1);
    start_op(1, 16'h7FFF, 16'h0001, 1'b0, 1'b1, 16'h8000, 1'b0, 1'b1);
    chk("b2b_busy", 1, 32'(busy_v[1]), 32'd1);
    wait_done(1);

    // Operand changes and a start pulse during RUN must be ignored
    @(negedge clk);
    start_op(1, 16'h0F0F, 16'h0101, 1'b0, 1'b1, 16'h1010, 1'b0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    a_v[1] = 16'hFFFF;
    b_v[1] = 16'hFFFF;
    start_v[1] = 1'b1;
    @(negedge clk);
    start_v[1] = 1'b0;
    wait_done(1);

    // Reset at RUN cycle 3 discards the operation
    @(negedge clk);
    start_op(0, 16'hAAAA, 16'h5555, 1'b0, 1'b0, 16'hFFFF, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    clear_held();
    chk_idle(0);
    chk_idle(1);
    reset = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("no_done_after_rst", 0, 32'(done_v[0]), 32'd0);
    end
    start_op(0, 16'hAAAA, 16'h5555, 1'b0, 1'b1, 16'hFFFF, 1'b0, 1'b0);
    wait_done(0);

`ifdef SERIAL_ADDER_SUB_EN
    @(negedge clk);
    start_op(0, 16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0);
    wait_done(0);
    @(negedge clk);
    start_op(1, 16'h8000, 16'h0001, 1'b1, 1'b1, 16'h7FFF, 1'b1, 1'b1);
    wait_done(1);
`endif

    repeat (2) @(negedge clk);
    chk("sb_empty", 0, 32'(sb_q[0].size()), 32'd0);
    chk("sb_empty", 1, 32'(sb_q[1].size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/serial_adder.md
Name: serial_adder

Overview:
- Multi-cycle, parametrised word adder. Adds two WIDTH-bit operands CHUNK bits per clock through a registered carry, with a start/done handshake.
- Successor to the single-bit half adder. Gives the Hack ALU path a low-area N-bit adder that can be scaled in width and throughput.
- Sits between operand registers and the ALU result mux.

Parameters:
- WIDTH, 16: operand and result width in bits. Must be a multiple of CHUNK.
- CHUNK, 1: bits added per RUN cycle. Legal values are 1..WIDTH.

Ports:
- clk  input  1  single system clock; all state updates on its rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request a new addition; sampled in IDLE or DONE only.
- in_a  input  WIDTH  operand A; captured on an accepted start.
- in_b  input  WIDTH  operand B; captured on an accepted start.
- busy  output  1  high while state is RUN.
- done  output  1  one-cycle pulse; result valid.
- sum  output  WIDTH  registered result; held until the next completion.
- carry  output  1  carry out of bit WIDTH-1.
- overflow  output  1  signed overflow: carry into the MSB XOR carry out of the MSB.

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-high.
- Reset values: state=IDLE, busy=0, done=0, sum=0, carry=0, overflow=0, chunk counter=0, internal carry=0.
- Reset mid-RUN: the partial result is discarded and the reset values apply on the next edge.
- Reset has priority over start.
- N = WIDTH/CHUNK.
- IDLE:
  - start=1 latches in_a and in_b into shift registers, clears the internal carry and counter, and moves to RUN.
  - start=0 stays in IDLE.
- RUN, each cycle:
  - Adds the low CHUNK bits of the A and B registers plus the internal carry.
  - Shifts the CHUNK result bits into the result shift register from the MSB end.
  - Shifts the A and B registers right by CHUNK.
  - Updates the internal carry and increments the counter.
  - After chunk N-1 completes, moves to DONE. On that same edge, sum, carry and overflow are loaded from the completed result.
- RUN ignores start and any changes on in_a/in_b.
- DONE:
  - done=1, busy=0, and the outputs are valid.
  - Next state is IDLE, or RUN if start=1. Back-to-back operation is allowed, so there is no dead cycle.
- Latency: start accepted at edge 0, busy high for N cycles, done high in cycle N+1. Throughput is one result per N+1 cycles.
- sum, carry and overflow change only on the RUN→DONE edge or on reset. They stay stable during RUN and hold the previous result.
- Arithmetic: the result is modulo 2^WIDTH. Carry is the unsigned carry-out. Overflow is computed from the final chunk's MSB carries.
- CHUNK=WIDTH degenerates to a single RUN cycle, with done in cycle 2.

Optional Feature:
- Macro: SERIAL_ADDER_SUB_EN.
- When defined:
  - Adds input port in_sub (1 bit), sampled with an accepted start.
  - in_sub=1 latches ~in_b instead of in_b and sets the internal carry to 1, so the block computes A-B in two's complement.
  - carry=1 means no borrow. Overflow follows the same MSB rule.
- When undefined: no in_sub port, and the block only adds.
- All latency and handshake rules are unchanged in both cases.

Decomposition:
- Package serial_adder_pkg holds:
  - the state encoding (IDLE=2'd0, RUN=2'd1, DONE=2'd2);
  - the constant function computing N;
  - the counter width as clog2(N) with a minimum of 1.
- One combinational sub-module, chunk_adder #(CHUNK):
  - ports a, b, cin → s, cout, c_msb_in;
  - a ripple chain of the existing full adders, which are built from the existing half adders.
  - c_msb_in is the carry into the chunk's top bit, used for overflow.

Test Plan:
1. WIDTH=16, CHUNK=1: reset held 2 cycles, then released → busy=0, done=0, sum=0x0000, carry=0, overflow=0.
2. WIDTH=16, CHUNK=1: start with in_a=0x1234, in_b=0x4321 → busy high for 16 cycles, done pulses in cycle 17, sum=0x5555, carry=0, overflow=0.
3. WIDTH=16, CHUNK=4:
   - 0xFFFF+0x0001 → sum=0x0000, carry=1, overflow=0, done in cycle 5.
   - Back-to-back start during DONE with 0x7FFF+0x0001 → sum=0x8000, carry=0, overflow=1, done 5 cycles later.
4. Change in_a/in_b and pulse start during RUN → ignored; the result matches the operands latched at the accepted start.
5. Assert reset at RUN cycle 3 of 0xAAAA+0x5555 → the next cycle shows IDLE, sum=0, done never pulses. A fresh start then yields sum=0xFFFF, carry=0.
6. SERIAL_ADDER_SUB_EN defined, in_sub=1:
   - 0x0005-0x0007 → sum=0xFFFE, carry=0, overflow=0.
   - 0x8000-0x0001 → sum=0x7FFF, carry=1, overflow=1.
